auth_ctrl_gen: RTL and testbench

Parametrised rider-authorisation controller, the next generation of the Segway authorisation block. It consumes command bytes from the BLE UART receiver and decodes configurable GO/STOP codes. It adds a heartbeat timeout that auto-stops when GO refreshes cease, and a debounced rider-off qualifier. Its `pwr_up` output enables the balance controller and steering, and the block sits between `UART_rx` and the balance/steer-enable logic inside `Segway`.

---
 rtl/auth_ctrl_gen_pkg.sv | 16 +
 rtl/auth_ctrl_gen_if.sv | 26 ++
 rtl/auth_ctrl_gen_debounce.sv | 40 ++++
 rtl/auth_ctrl_gen.sv | 133 +++++++++++++
 tb/tb_auth_ctrl_gen.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/auth_ctrl_gen_pkg.sv
// Shared definitions for the rider-authorisation controller.
//   auth_state_t    : controller states, encoded as they appear on auth_state
//   AUTH_GO_CODE    : default byte that authorises or refreshes power-up ('G')
//   AUTH_STOP_CODE  : default byte that requests a stop ('S')
package auth_pkg;

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      PWR1 = 2'd1,
      PWR2 = 2'd2
   } auth_state_t;

   localparam logic [7:0] AUTH_GO_CODE   = 8'h47;
   localparam logic [7:0] AUTH_STOP_CODE = 8'h53;

endpackage

// File: rtl/auth_ctrl_gen_if.sv
// Byte handshake between the BLE UART receiver and the authorisation block.
//   rx_data    : received command byte
//   rx_rdy     : byte valid, held by the receiver until acknowledged
//   clr_rx_rdy : one-cycle acknowledge from the consumer
// master = UART receiver side, slave = authorisation controller side.
interface auth_ctrl_gen_if #(
   parameter int DATA_W = 8
);

   logic [DATA_W-1:0] rx_data;
   logic              rx_rdy;
   logic              clr_rx_rdy;

   modport master (
      output rx_data,
      output rx_rdy,
      input  clr_rx_rdy
   );

   modport slave (
      input  rx_data,
      input  rx_rdy,
      output clr_rx_rdy
   );

endinterface

// File: rtl/auth_ctrl_gen_debounce.sv
// Rider-off qualifier: a saturating run-length counter on the raw rider_off
// indication.
//   clk, rst    : system clock, synchronous active-high reset
//   rider_off   : raw rider-absent indication
//   rider_off_q : high once rider_off has been high for OFF_DEB consecutive
//                 rising edges; drops after the first low sample
module rider_off_debounce #(
   parameter int OFF_DEB = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic rider_off,
   output logic rider_off_q
);

   localparam int CW = $clog2(OFF_DEB + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(OFF_DEB);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = '0;
      if (rider_off) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Decoded straight from the flop, so the qualifier is high right after
   // the OFF_DEB-th high sample.
   assign rider_off_q = (cnt_q == CNT_MAX);

endmodule

// File: rtl/auth_ctrl_gen.sv
// Rider-authorisation controller: decodes GO/STOP command bytes from the UART
// receiver, runs a heartbeat timeout in PWR1 and gates power with a debounced
// rider-off qualifier.
//   clk, rst   : system clock, synchronous active-high reset
//   rx_if      : byte handshake (rx_data, rx_rdy in; clr_rx_rdy out)
//   rider_off  : raw rider-absent indication
//   pwr_up     : power enable for balance controller and steering
//   auth_state : current state (OFF=0, PWR1=1, PWR2=2)
//   tmo_evt    : one-cycle pulse when the heartbeat timeout fires
//
// state | meaning
// ------+--------------------------------------------------------------
// OFF   | no power; waiting for GO
// PWR1  | powered and authorised; heartbeat timer running
// PWR2  | powered after STOP/timeout; drops to OFF once rider is off
module auth_ctrl_gen
   import auth_pkg::*;
#(
   parameter int                DATA_W    = 8,
   parameter logic [DATA_W-1:0] GO_CODE   = DATA_W'(AUTH_GO_CODE),
   parameter logic [DATA_W-1:0] STOP_CODE = DATA_W'(AUTH_STOP_CODE),
   parameter int                TMO_CYC   = 2**24,
   parameter int                OFF_DEB   = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   auth_ctrl_gen_if.slave        rx_if,
   input  logic                  rider_off,
   output logic                  pwr_up,
   output logic [1:0]            auth_state,
   output logic                  tmo_evt
);

   localparam bit TMO_EN = (TMO_CYC != 0);
   localparam int TW     = TMO_EN ? $clog2(TMO_CYC + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TMO_CYC - 1) : '0;

   auth_state_t       state_q, state_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] byte_q, byte_d;
   logic              clr_q, clr_d;
   logic              pwr_q, pwr_d;
   logic              tmo_q, tmo_d;
   logic [TW-1:0]     tmr_q, tmr_d;

   logic rider_off_q;
   logic accept;
   logic go;
   logic stop;
   logic tmo_fire;

   rider_off_debounce #(
      .OFF_DEB (OFF_DEB)
   ) u_deb (
      .clk         (clk),
      .rst         (rst),
      .rider_off   (rider_off),
      .rider_off_q (rider_off_q)
   );

   always_comb begin
      // A byte is captured once, then blocked for the capture cycle and the
      // acknowledge cycle so a still-high rx_rdy is not consumed twice.
      accept   = rx_if.rx_rdy && !clr_q && !pend_q;
      pend_d   = accept;
      byte_d   = accept ? rx_if.rx_data : byte_q;
      go       = pend_q && (byte_q == GO_CODE);
      stop     = pend_q && (byte_q == STOP_CODE);
      tmo_fire = TMO_EN && (state_q == PWR1) && (tmr_q == TMO_LAST);

      state_d  = state_q;
      clr_d    = pend_q;
      tmo_d    = 1'b0;
      tmr_d    = '0;

      case (state_q)
         OFF: begin
            if (go) begin
               state_d = PWR1;
            end
         end
         PWR1: begin
            // GO outranks both STOP and a coincident timeout.
            if (!go) begin
               if (stop || tmo_fire) begin
                  tmo_d   = tmo_fire;
                  state_d = rider_off_q ? OFF : PWR2;
               end else if (TMO_EN) begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
         end
         PWR2: begin
            if (go) begin
               state_d = PWR1;
            end else if (rider_off_q) begin
               state_d = OFF;
            end
         end
         default: begin
            state_d = OFF;
         end
      endcase

      pwr_d = (state_d != OFF);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OFF;
         pend_q  <= 1'b0;
         byte_q  <= '0;
         clr_q   <= 1'b0;
         pwr_q   <= 1'b0;
         tmo_q   <= 1'b0;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         byte_q  <= byte_d;
         clr_q   <= clr_d;
         pwr_q   <= pwr_d;
         tmo_q   <= tmo_d;
         tmr_q   <= tmr_d;
      end
   end

   assign rx_if.clr_rx_rdy = clr_q;
   assign pwr_up           = pwr_q;
   assign auth_state       = state_q;
   assign tmo_evt          = tmo_q;

endmodule

// File: tb/tb_auth_ctrl_gen.sv
// Bench for auth_ctrl_gen with TMO_CYC=1000, OFF_DEB=16: directed scenarios
// with fixed expectations, then randomized traffic against an edge-level
// behavioural model of the authorisation rules.
module tb_auth_ctrl_gen;

   localparam int TMO = 1000;
   localparam int DEB = 16;
   localparam logic [7:0] GO   = 8'h47;
   localparam logic [7:0] STOP = 8'h53;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rider_off = 1'b0;
   logic       pwr_up;
   logic       tmo_evt;
   logic [1:0] auth_state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   auth_ctrl_gen_if #(.DATA_W(8)) rx_if ();

   auth_ctrl_gen #(
      .DATA_W    (8),
      .GO_CODE   (GO),
      .STOP_CODE (STOP),
      .TMO_CYC   (TMO),
      .OFF_DEB   (DEB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_if      (rx_if),
      .rider_off  (rider_off),
      .pwr_up     (pwr_up),
      .auth_state (auth_state),
      .tmo_evt    (tmo_evt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural model ----------------
   // m_since: edges spent in PWR1 since entry or last GO took effect.
   // m_run:   consecutive edges rider_off was sampled high.
   // m_busy:  edges remaining before another byte may be taken.
   int         m_st, m_since, m_run, m_busy;
   logic       m_pend, m_clr, m_tmo, m_pwr;
   logic [7:0] m_byte;
   logic       mg_go, mg_stop, mg_qual, mg_tout, mg_acc;

   initial begin
      m_st = 0; m_since = 0; m_run = 0; m_busy = 0;
      m_pend = 0; m_clr = 0; m_tmo = 0; m_pwr = 0; m_byte = 8'h00;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_st = 0; m_since = 0; m_run = 0; m_busy = 0;
            m_pend = 0; m_clr = 0; m_tmo = 0; m_pwr = 0;
         end else begin
            mg_go   = m_pend && (m_byte == GO);
            mg_stop = m_pend && (m_byte == STOP);
            mg_qual = (m_run >= DEB);
            mg_tout = (m_st == 1) && (m_since + 1 == TMO);
            m_tmo   = 1'b0;
            if (m_st == 0) begin
               if (mg_go) begin m_st = 1; m_since = 0; end
            end else if (m_st == 1) begin
               if (mg_go) m_since = 0;
               else if (mg_stop || mg_tout) begin
                  m_tmo = mg_tout;
                  m_st  = mg_qual ? 0 : 2;
               end else m_since = m_since + 1;
            end else begin
               if (mg_go) begin m_st = 1; m_since = 0; end
               else if (mg_qual) m_st = 0;
            end
            m_pwr  = (m_st != 0);
            m_clr  = m_pend;
            mg_acc = rx_if.rx_rdy && (m_busy == 0);
            m_busy = mg_acc ? 2 : ((m_busy > 0) ? m_busy - 1 : 0);
            m_pend = mg_acc;
            if (mg_acc) m_byte = rx_if.rx_data;
            m_run  = rider_off ? ((m_run < 1000000) ? m_run + 1 : m_run) : 0;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a byte like the UART does and drop rx_rdy once acknowledged.
   // Returns at the falling edge after the acknowledge edge; ent is that edge.
   task automatic send_byte(input logic [7:0] b, output int ent);
      bit ok = 0;
      @(negedge clk);
      rx_if.rx_data = b;
      rx_if.rx_rdy  = 1'b1;
      for (int i = 0; i < 8 && !ok; i++) begin
         @(negedge clk);
         if (rx_if.clr_rx_rdy === 1'b1) ok = 1;
      end
      rx_if.rx_rdy = 1'b0;
      ent = cyc;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL send_ack byte=%h got=no_ack expected=ack", b);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++;
      if (pwr_up !== 1'b0 || auth_state !== 2'd0 || rx_if.clr_rx_rdy !== 1'b0 || tmo_evt !== 1'b0) begin
         failures++;
         $display("FAIL reset_vals got pwr=%b st=%0d clr=%b tmo=%b expected 0/0/0/0",
                  pwr_up, auth_state, rx_if.clr_rx_rdy, tmo_evt);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_go_latency();
      @(negedge clk);
      rx_if.rx_data = GO;
      rx_if.rx_rdy  = 1'b1;
      tick();
      checks++;
      if (rx_if.clr_rx_rdy !== 1'b0 || pwr_up !== 1'b0) begin
         failures++;
         $display("FAIL go_edgeN got clr=%b pwr=%b expected 0/0", rx_if.clr_rx_rdy, pwr_up);
      end
      tick();
      checks++;
      if (rx_if.clr_rx_rdy !== 1'b1 || pwr_up !== 1'b1 || auth_state !== 2'd1) begin
         failures++;
         $display("FAIL go_edgeN1 got clr=%b pwr=%b st=%0d expected 1/1/1",
                  rx_if.clr_rx_rdy, pwr_up, auth_state);
      end
      @(negedge clk);
      rx_if.rx_rdy = 1'b0;
      tick();
      checks++;
      if (rx_if.clr_rx_rdy !== 1'b0) begin
         failures++;
         $display("FAIL go_clr_pulse got clr=%b expected 0", rx_if.clr_rx_rdy);
      end
   endtask

   task automatic test_stop_rider();
      int ent;
      send_byte(STOP, ent);
      checks++;
      if (auth_state !== 2'd2 || pwr_up !== 1'b1) begin
         failures++;
         $display("FAIL stop_to_pwr2 got st=%0d pwr=%b expected 2/1", auth_state, pwr_up);
      end
      rider_off = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         if (k == 16) begin
            checks++;
            if (auth_state !== 2'd2) begin
               failures++;
               $display("FAIL rider_edge16 got st=%0d expected 2", auth_state);
            end
         end
         if (k == 17) begin
            checks++;
            if (auth_state !== 2'd0 || pwr_up !== 1'b0) begin
               failures++;
               $display("FAIL rider_edge17 got st=%0d pwr=%b expected 0/0", auth_state, pwr_up);
            end
         end
      end
   endtask

   task automatic test_timeout();
      int ent;
      bit seen = 0;
      send_byte(GO, ent);
      for (int i = 0; i < 1100; i++) begin
         tick();
         if (tmo_evt === 1'b1) begin seen = 1; break; end
      end
      checks++;
      if (!seen || (cyc - ent) != TMO || auth_state !== 2'd0) begin
         failures++;
         $display("FAIL timeout_fire got seen=%0d after=%0d st=%0d expected 1/%0d/0",
                  seen, cyc - ent, auth_state, TMO);
      end
      tick();
      checks++;
      if (tmo_evt !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse got tmo=%b expected 0", tmo_evt);
      end
   endtask

   task automatic test_heartbeat();
      int ent;
      int bad;
      @(negedge clk);
      rider_off = 1'b0;
      send_byte(GO, ent);
      for (int r = 0; r < 6; r++) begin
         bad = 0;
         for (int i = 0; i < 897; i++) begin
            tick();
            if (tmo_evt !== 1'b0 || auth_state !== 2'd1) bad++;
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL heartbeat round=%0d got bad_cycles=%0d expected 0", r, bad);
         end
         send_byte(GO, ent);
      end
   endtask

   task automatic test_pwr2_race();
      int ent;
      send_byte(STOP, ent);
      rider_off = 1'b1;
      repeat (15) tick();
      @(negedge clk);
      rider_off = 1'b0;
      repeat (3) tick();
      checks++;
      if (auth_state !== 2'd2) begin
         failures++;
         $display("FAIL pwr2_short_off got st=%0d expected 2", auth_state);
      end
      @(negedge clk);
      rider_off = 1'b1;
      repeat (15) tick();
      @(negedge clk);
      rx_if.rx_data = GO;
      rx_if.rx_rdy  = 1'b1;
      tick();
      checks++;
      if (auth_state !== 2'd2) begin
         failures++;
         $display("FAIL race_edge16 got st=%0d expected 2", auth_state);
      end
      tick();
      checks++;
      if (auth_state !== 2'd1 || rx_if.clr_rx_rdy !== 1'b1) begin
         failures++;
         $display("FAIL race_go_wins got st=%0d clr=%b expected 1/1", auth_state, rx_if.clr_rx_rdy);
      end
      @(negedge clk);
      rx_if.rx_rdy = 1'b0;
      rider_off    = 1'b0;
      tick();
      checks++;
      if (auth_state !== 2'd1) begin
         failures++;
         $display("FAIL race_hold got st=%0d expected 1", auth_state);
      end
   endtask

   task automatic test_misc();
      int ent;
      int acks = 0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) tick();
      @(negedge clk);
      rst = 1'b0;
      send_byte(8'h41, ent);
      tick();
      checks++;
      if (auth_state !== 2'd0) begin
         failures++;
         $display("FAIL other_code got st=%0d expected 0", auth_state);
      end
      @(negedge clk);
      rx_if.rx_data = GO;
      rx_if.rx_rdy  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rx_if.clr_rx_rdy === 1'b1) acks++;
         if (i == 2) begin
            @(negedge clk);
            rx_if.rx_rdy = 1'b0;
         end
      end
      checks++;
      if (acks != 1 || auth_state !== 2'd1) begin
         failures++;
         $display("FAIL held_rdy got acks=%0d st=%0d expected 1/1", acks, auth_state);
      end
      repeat (50) tick();
      @(negedge clk);
      rst = 1'b1;
      rx_if.rx_data = GO;
      rx_if.rx_rdy  = 1'b1;
      tick();
      checks++;
      if (pwr_up !== 1'b0 || auth_state !== 2'd0 || rx_if.clr_rx_rdy !== 1'b0 || tmo_evt !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got pwr=%b st=%0d clr=%b tmo=%b expected 0/0/0/0",
                  pwr_up, auth_state, rx_if.clr_rx_rdy, tmo_evt);
      end
      tick();
      checks++;
      if (rx_if.clr_rx_rdy !== 1'b0) begin
         failures++;
         $display("FAIL reset_no_ack got clr=%b expected 0", rx_if.clr_rx_rdy);
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      tick();
      checks++;
      if (rx_if.clr_rx_rdy !== 1'b1 || auth_state !== 2'd1) begin
         failures++;
         $display("FAIL post_reset_byte got clr=%b st=%0d expected 1/1", rx_if.clr_rx_rdy, auth_state);
      end
      @(negedge clk);
      rx_if.rx_rdy = 1'b0;
   endtask

   task automatic test_random();
      int rate;
      int r;
      for (int i = 0; i < 4000; i++) begin
         rate = (i < 2000) ? 16 : 500;
         @(negedge clk);
         if (rx_if.rx_rdy === 1'b1 && rx_if.clr_rx_rdy === 1'b1) begin
            rx_if.rx_rdy = 1'b0;
         end else if (rx_if.rx_rdy === 1'b0 && $urandom_range(rate - 1) == 0) begin
            r = $urandom_range(3);
            rx_if.rx_data = (r == 0) ? GO : (r == 1) ? STOP : 8'($urandom_range(255));
            rx_if.rx_rdy  = 1'b1;
         end
         if ($urandom_range(39) == 0) rider_off = ~rider_off;
         tick();
         checks++;
         if (auth_state !== 2'(m_st) || pwr_up !== m_pwr ||
             rx_if.clr_rx_rdy !== m_clr || tmo_evt !== m_tmo) begin
            failures++;
            $display("FAIL random cyc=%0d got st=%0d pwr=%b clr=%b tmo=%b expected %0d/%b/%b/%b",
                     cyc, auth_state, pwr_up, rx_if.clr_rx_rdy, tmo_evt, m_st, m_pwr, m_clr, m_tmo);
         end
      end
   endtask

   initial begin
      rx_if.rx_data = 8'h00;
      rx_if.rx_rdy  = 1'b0;
      test_reset();
      test_go_latency();
      test_stop_rider();
      test_timeout();
      test_heartbeat();
      test_pwr2_race();
      test_misc();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got no_finish expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
